// File: rtl/csrbrg_pkg.sv
// ============================================================================
//  Module   : csrbrg_pkg
//  Purpose  : Shared types and constants for the Wishbone-to-CSR bridge.
//             Holds the CSR bus geometry and the bridge FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package csrbrg_pkg;

    // CSR bus geometry: 14-bit word address, 32-bit data
    localparam int CSR_AW = 14;
    localparam int CSR_DW = 32;

    // Bridge FSM states. READ3 is only reachable when the read-data
    // pipeline stage is built in; it stays in the encoding either way so
    // the type is identical across configurations.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ1 = 3'd2,
        ST_READ2 = 3'd3,
        ST_READ3 = 3'd4,
        ST_ACK   = 3'd5
    } csrbrg_state_t;

endpackage : csrbrg_pkg

`default_nettype wire

// File: rtl/wb_csr_bridge.sv
// ============================================================================
//  Module   : wb_csr_bridge
//  Purpose  : Wishbone classic slave to CSR-bus initiator. Each WB read or
//             write becomes exactly one CSR access (14-bit word address,
//             32-bit data). CSR slaves return read data registered one
//             cycle after the address; their outputs are OR-ed externally
//             onto csr_di.
//  Revision : 1.0  initial release
//
//  Parameters
//    ADR_LSB   lowest wb_adr_i bit mapped to csr_a[0]
//
//  Ports
//    sys_clk    in   1   clock, rising edge
//    sys_rst    in   1   synchronous reset, active high
//    wb_adr_i   in   32  byte address
//    wb_dat_i   in   32  write data
//    wb_dat_o   out  32  read data, valid with wb_ack_o on reads
//    wb_cyc_i   in   1   cycle valid
//    wb_stb_i   in   1   strobe
//    wb_we_i    in   1   1 = write
//    wb_sel_i   in   4   unused, CSR accesses are always 32-bit
//    wb_ack_o   out  1   single-cycle acknowledge
//    csr_a      out  14  CSR word address
//    csr_we     out  1   CSR write strobe
//    csr_do     out  32  CSR write data
//    csr_di     in   32  OR of all CSR slave read data
//
//  Configuration macro
//    CSRBRG_RDPIPE_EN  when defined, adds a READ3 state that registers
//                      csr_di once more before wb_dat_o (read ack one
//                      cycle later; writes unchanged).
// ============================================================================
`default_nettype none

module wb_csr_bridge
    import csrbrg_pkg::*;
#(
    parameter int ADR_LSB = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst,

    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    output logic                wb_ack_o,

    output logic [CSR_AW-1:0]   csr_a,
    output logic                csr_we,
    output logic [CSR_DW-1:0]   csr_do,
    input  logic [CSR_DW-1:0]   csr_di
);

    csrbrg_state_t      r_state;
    logic               r_ack;
    logic [31:0]        r_dat;
    logic [CSR_AW-1:0]  r_csr_a;
    logic               r_csr_we;
    logic [CSR_DW-1:0]  r_csr_do;
`ifdef CSRBRG_RDPIPE_EN
    logic [CSR_DW-1:0]  r_rd_q;
`endif

    logic               w_req;
    logic               w_unused;

    assign w_req = wb_cyc_i & wb_stb_i;

    // Byte lanes and address bits outside the CSR window carry no meaning here
    assign w_unused = ^{wb_sel_i, wb_adr_i};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_csr_a  <= '0;
            r_csr_we <= 1'b0;
            r_csr_do <= '0;
`ifdef CSRBRG_RDPIPE_EN
            r_rd_q   <= '0;
`endif
        end else begin
            // Both strobes are single-cycle pulses; only the states below
            // that need them raise them again.
            r_ack    <= 1'b0;
            r_csr_we <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_csr_a  <= wb_adr_i[ADR_LSB +: CSR_AW];
                        r_csr_do <= wb_dat_i;
                        if (wb_we_i) begin
                            r_csr_we <= 1'b1;
                            r_state  <= ST_WRITE;
                        end else begin
                            r_state  <= ST_READ1;
                        end
                    end
                end

                // csr_we is high during this cycle; an abort here cannot
                // take back the write the slave has already seen.
                ST_WRITE: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end

                // Address is on the bus; the slave registers its data now.
                ST_READ1: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_READ2;
                    end
                end

                // csr_di is valid in this cycle.
                ST_READ2: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else begin
`ifdef CSRBRG_RDPIPE_EN
                        r_rd_q  <= csr_di;
                        r_state <= ST_READ3;
`else
                        r_dat   <= csr_di;
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
`endif
                    end
                end

`ifdef CSRBRG_RDPIPE_EN
                ST_READ3: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dat   <= r_rd_q;
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
`endif

                // Ack is visible this cycle; a request still presented by
                // the master is deliberately not sampled until IDLE.
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign csr_a    = r_csr_a;
    assign csr_we   = r_csr_we;
    assign csr_do   = r_csr_do;

endmodule : wb_csr_bridge

`default_nettype wire

// File: tb/tb_wb_csr_bridge.sv
// ============================================================================
//  Module   : tb_wb_csr_bridge
//  Purpose  : Self-checking bench for wb_csr_bridge. A simple CSR slave
//             (registered read data) sits on the CSR side; expected values
//             come from an address-indexed reference store and the access
//             latencies of the bridge protocol.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_csr_bridge;

`ifdef CSRBRG_RDPIPE_EN
    localparam int RD_LAT = 4;
`else
    localparam int RD_LAT = 3;
`endif
    localparam int WR_LAT = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] csr_di;

    always #5 sys_clk = ~sys_clk;

    wb_csr_bridge #(.ADR_LSB(2)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_ack_o (wb_ack_o),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .csr_di   (csr_di)
    );

    // CSR slave: storage written on csr_we, read data registered one cycle
    // after the address.
    logic [31:0] slave_mem [int];
    logic [31:0] slave_q = 32'h0;
    always @(posedge sys_clk) begin
        if (csr_we) slave_mem[int'(csr_a)] = csr_do;
        slave_q <= slave_mem.exists(int'(csr_a)) ? slave_mem[int'(csr_a)] : 32'h0;
    end
    assign csr_di = slave_q;

    // Count write strobes seen by the slave
    int we_pulses = 0;
    always @(posedge sys_clk) if (csr_we === 1'b1) we_pulses++;

    // Reference model state
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;
    logic [13:0] last_a;
    logic [31:0] last_do;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] word_of(input logic [31:0] adr);
        return 14'((adr / 4) % 16384);
    endfunction

    // One complete WB access, entered and left at a falling edge with the
    // bridge ready to sample at the next rising edge. With hold=1 cyc/stb
    // stay high through the ack cycle.
    task automatic access(input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, input bit hold);
        int          lat;
        int          p0;
        logic [13:0] ea;
        logic [31:0] ed;
        ea  = word_of(adr);
        lat = we ? WR_LAT : RD_LAT;
        ed  = we ? last_rd : (ref_mem.exists(int'(ea)) ? ref_mem[int'(ea)] : 32'h0);
        p0  = we_pulses;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = 4'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge sys_clk);
            if (k == 1) begin
                chk("csr_a", {18'h0, csr_a}, {18'h0, ea});
                chk("csr_we_t1", {31'h0, csr_we}, {31'h0, we});
                chk("csr_do", csr_do, dat);
            end else begin
                chk("csr_we_late", {31'h0, csr_we}, 32'h0);
            end
            if (k < lat) chk("early_ack", {31'h0, wb_ack_o}, 32'h0);
        end
        chk(we ? "wr_ack" : "rd_ack", {31'h0, wb_ack_o}, 32'h1);
        chk(we ? "wr_dat_o_hold" : "rd_dat_o", wb_dat_o, ed);
        if (we) ref_mem[int'(ea)] = dat;
        else    last_rd = ed;
        last_a  = ea;
        last_do = dat;
        if (!hold) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
        @(negedge sys_clk);
        chk("ack_one_cycle", {31'h0, wb_ack_o}, 32'h0);
        chk("we_pulse_count", 32'(we_pulses - p0), {31'h0, we});
        chk("csr_a_hold", {18'h0, csr_a}, {18'h0, last_a});
    endtask

    initial begin
        logic [31:0] pool [8];
        logic [13:0] ea;
        int          p0;
        bit          seen_ack;

        sys_rst  = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'h0;
        last_rd  = 32'h0;
        last_a   = 14'h0;
        last_do  = 32'h0;

        // Reset held two cycles
        repeat (2) @(negedge sys_clk);
        chk("rst_ack",    {31'h0, wb_ack_o}, 32'h0);
        chk("rst_dat_o",  wb_dat_o, 32'h0);
        chk("rst_csr_a",  {18'h0, csr_a}, 32'h0);
        chk("rst_csr_we", {31'h0, csr_we}, 32'h0);
        chk("rst_csr_do", csr_do, 32'h0);
        sys_rst = 1'b0;

        // stb without cyc must not start anything
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h0000_1004;
        wb_dat_i = 32'hDEAD_BEEF;
        p0 = we_pulses;
        repeat (3) @(negedge sys_clk);
        chk("stb_only_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("stb_only_we",  32'(we_pulses - p0), 32'h0);
        chk("stb_only_a",   {18'h0, csr_a}, 32'h0);
        wb_stb_i = 1'b0;

        // Directed write then read of the same register
        access(1'b1, 32'h0000_1004, 32'h0000_0036, 1'b0);
        access(1'b0, 32'h0000_1004, 32'h0, 1'b0);

        // Back-to-back write then read with stb held through the ack cycle
        access(1'b1, 32'h0000_2000, 32'hA5A5_0001, 1'b1);
        access(1'b0, 32'h0000_2000, 32'h0, 1'b1);
        access(1'b0, 32'h0000_1004, 32'h0, 1'b0);

        // Randomized traffic over a small address pool (with stray upper bits)
        for (int i = 0; i < 8; i++) pool[i] = {$urandom} & 32'hFFFF_FFFC;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 7)] | ({$urandom} & 32'h0000_0003);
            access(1'($urandom), a, $urandom, 1'($urandom));
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge sys_clk);

        // Abort a read in READ1: no ack, no write strobe, bridge returns idle
        ea = word_of(32'h0000_3008);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h0000_3008;
        wb_dat_i = 32'h1234_5678;
        p0 = we_pulses;
        @(negedge sys_clk);
        chk("abort_csr_a", {18'h0, csr_a}, {18'h0, ea});
        wb_cyc_i = 1'b0;
        seen_ack = 1'b0;
        repeat (5) begin
            @(negedge sys_clk);
            if (wb_ack_o === 1'b1) seen_ack = 1'b1;
        end
        chk("abort_no_ack", {31'h0, seen_ack}, 32'h0);
        chk("abort_no_we",  32'(we_pulses - p0), 32'h0);
        chk("abort_dat_o",  wb_dat_o, last_rd);
        wb_stb_i = 1'b0;
        last_a  = ea;
        access(1'b0, 32'h0000_2000, 32'h0, 1'b0);

        // Reset asserted in WRITE: outputs cleared next edge, no ack.
        // The strobe already on the bus still reaches the slave.
        ea = word_of(32'h0000_1004);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h0000_1004;
        wb_dat_i = 32'h0000_0077;
        @(negedge sys_clk);
        chk("rstw_we_t1", {31'h0, csr_we}, 32'h1);
        sys_rst = 1'b1;
        ref_mem[int'(ea)] = 32'h0000_0077;
        @(negedge sys_clk);
        chk("rstw_we",    {31'h0, csr_we}, 32'h0);
        chk("rstw_ack",   {31'h0, wb_ack_o}, 32'h0);
        chk("rstw_csr_a", {18'h0, csr_a}, 32'h0);
        chk("rstw_dat_o", wb_dat_o, 32'h0);
        chk("rstw_do",    csr_do, 32'h0);
        sys_rst  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        last_rd  = 32'h0;
        @(negedge sys_clk);
        chk("rstw_no_ack", {31'h0, wb_ack_o}, 32'h0);
        access(1'b0, 32'h0000_1004, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_wb_csr_bridge

`default_nettype wire
